// File: rtl/mmio_uart_port.sv
// Memory-mapped I/O responder on the data-memory bus: output port, synchronized input
// port and an 8N1 UART transmitter fed from a small byte FIFO.
module mmio_uart_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uartState_t;

    logic [7:0]        sync1_r, sync2_r;
    logic [31:0]       portOut_r;
    logic [7:0]        fifoMem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_r, rdPtr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    uartState_t        state_r;
    logic [BAUD_W-1:0] baudCnt_r;
    logic [2:0]        bitCnt_r;
    logic [7:0]        shift_r;
    logic              tx_r;

    logic        hit_s, storeHit_s, pushReq_s, pushOk_s, pop_s;
    logic        full_s, empty_s, busy_s, baudLast_s;
    logic [1:0]  offset_s;
    logic [31:0] status_s, readData_s;
    logic        unusedAddrBits_s;

    assign hit_s            = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset_s         = Address[3:2];
    assign unusedAddrBits_s = ^Address[1:0];
    assign storeHit_s       = MemWrite && hit_s;
    assign pushReq_s        = storeHit_s && (offset_s == 2'd2);
    assign full_s           = (count_r == CNT_FULL);
    assign empty_s          = (count_r == {CNT_W{1'b0}});
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign pushOk_s         = pushReq_s && !full_s;
    assign pop_s            = (state_r == IDLE) && !empty_s;
    assign busy_s           = (state_r != IDLE);
    assign baudLast_s       = (baudCnt_r == BAUD_LAST);
    assign status_s         = {16'h0000, 8'(count_r), 4'h0, overflow_r, empty_s, full_s, busy_s};

    // Load data mux; reflects pre-edge state even when a store hits in the same cycle.
    always_comb begin
        readData_s = 32'h0000_0000;
        if (MemRead && hit_s) begin
            case (offset_s)
                2'd0:    readData_s = portOut_r;
                2'd1:    readData_s = {24'h00_0000, sync2_r};
                2'd3:    readData_s = status_s;
                default: readData_s = 32'h0000_0000;
            endcase
        end else begin
            readData_s = 32'h0000_0000;
        end
    end

    assign ReadData = readData_s;
    assign Hit      = hit_s;
    assign PortOut  = portOut_r;
    assign tx       = tx_r;

    // Two-flop synchronizer for the asynchronous input pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
        end else begin
            sync1_r <= PortIn;
            sync2_r <= sync1_r;
        end
    end

    // Output port register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            portOut_r <= 32'h0000_0000;
        end else if (storeHit_s && (offset_s == 2'd0)) begin
            portOut_r <= WriteData;
        end
    end

    // TX FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_r[i] <= 8'h00;
            end
            wrPtr_r    <= {PTR_W{1'b0}};
            rdPtr_r    <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (pushOk_s) begin
                fifoMem_r[wrPtr_r] <= WriteData[7:0];
                wrPtr_r            <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({pushOk_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (pushReq_s && full_s) begin
                overflow_r <= 1'b1;
            end else if (storeHit_s && (offset_s == 2'd3)) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // UART 8N1 transmitter; tx is registered and set on each state transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            baudCnt_r <= {BAUD_W{1'b0}};
            bitCnt_r  <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    baudCnt_r <= {BAUD_W{1'b0}};
                    if (pop_s) begin
                        shift_r <= fifoMem_r[rdPtr_r];
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                START: begin
                    if (baudLast_s) begin
                        state_r   <= DATA;
                        baudCnt_r <= {BAUD_W{1'b0}};
                        bitCnt_r  <= 3'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        baudCnt_r <= baudCnt_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baudLast_s) begin
                        baudCnt_r <= {BAUD_W{1'b0}};
                        if (bitCnt_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bitCnt_r <= bitCnt_r + 3'd1;
                            shift_r  <= {1'b0, shift_r[7:1]};
                            tx_r     <= shift_r[1];
                        end
                    end else begin
                        baudCnt_r <= baudCnt_r + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baudLast_s) begin
                        state_r   <= IDLE;
                        baudCnt_r <= {BAUD_W{1'b0}};
                    end else begin
                        baudCnt_r <= baudCnt_r + BAUD_W'(1);
                    end
                    tx_r <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    baudCnt_r <= {BAUD_W{1'b0}};
                    tx_r      <= 1'b1;
                end
            endcase
        end
    end

endmodule
